cva6_dm_mailbox: RTL and testbench
==================================

# cva6_dm_mailbox

Debug-module-side responder for the CVA6 debug ROM handshake. It decodes the hart's memory accesses into the debug region at `DmBaseAddress`, tracks hart run/halt state, and exposes go/resume flags and the two 32-bit memory-mapped data registers (`DataAddr` = 0x380) to the debugger command logic. It sits between the core's OBI-style debug-region slave port and the debug module front end.

## Interface
- `AddrWidth`, 64: hart-side address width.
- `BaseAddr`, 64'h0: region base; offsets below are added to it.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  hart request.
- `gnt_o`  out  1  grant.
- `addr_i`  in  AddrWidth  byte address.
- `we_i`  in  1  write enable.
- `be_i`  in  8  byte enables.
- `wdata_i`  in  64  write data.
- `rvalid_o`  out  1  read/write response valid.
- `rdata_o`  out  64  response data.
- `cmd_go_i`  in  1  debugger: execute abstract command (pulse).
- `cmd_resume_i`  in  1  debugger: resume request (pulse).
- `cmderr_clr_i`  in  1  clear sticky `cmderr_o`.
- `dbg_we_i`  in  1  debugger data write.
- `dbg_idx_i`  in  1  data register index (0 = data0, 1 = data1).
- `dbg_wdata_i`  in  32  debugger write data.
- `data0_o`, `data1_o`  out  32  data register contents.
- `halted_o`  out  1  hart parked in debug ROM.
- `cmd_busy_o`  out  1  abstract command in flight.
- `resumeack_o`  out  1  one-cycle pulse on resume completion.
- `cmderr_o`  out  1  sticky exception-during-command flag.

## Operation
- Offsets: 0x100 HALTED (W), 0x104 GOING (W), 0x108 RESUMING (W), 0x10C EXCEPTION (W), 0x380 DATA (R/W; bits 31:0 = data0, 63:32 = data1), 0x400 FLAGS (R; bit0 = go, bit1 = resume, other bits 0).
- Match is on the 8-byte-aligned address; the 32-bit write registers decode on `addr_i[AddrWidth-1:2]`, and any enabled byte counts as a write.
- Unmapped reads return 0. Unmapped writes and writes to FLAGS are ignored. All accesses still get a response.
- States:
  - RUNNING: default.
  - HALTED: a HALTED write from any state goes to HALTED.
  - In HALTED, `cmd_go_i` while not busy sets go and `cmd_busy_o`, and moves to CMD.
  - In CMD, a GOING write clears go. A HALTED write clears `cmd_busy_o` and moves to HALTED. An EXCEPTION write sets `cmderr_o`, clears busy and go, and moves to HALTED.
  - In HALTED, `cmd_resume_i` while not busy sets resume and moves to RESUMING.
  - In RESUMING, a RESUMING write clears resume, pulses `resumeack_o` and moves to RUNNING.
- `cmd_go_i` and `cmd_resume_i` outside HALTED, or while busy, are ignored. If both arrive in the same cycle, go wins.
- `halted_o` is 1 in HALTED, CMD and RESUMING.
- DATA register:
  - Hart writes honour `be_i` per byte.
  - `dbg_we_i` is ignored while `cmd_busy_o` = 1.
  - If the hart and the debugger write the same cycle, the hart wins on each enabled byte and the debugger wins on the remaining bytes of its word.
- `cmderr_o` stays set until `cmderr_clr_i`. If set and clear arrive in the same cycle, set wins.

## Timing
- `gnt_o` = `req_i`, combinational; every request is accepted the same cycle.
- `rvalid_o` is asserted exactly one cycle after an accepted request. `rdata_o` is registered and holds the value sampled in the grant cycle, so a read returns pre-write data for a same-cycle write.
- State, flags and data update on the clock edge that ends the grant cycle. FLAGS reflects the change on the next access.
- `resumeack_o` is high for one cycle, the cycle after the RESUMING write is granted.
- Reset values:
  - state RUNNING.
  - go = resume = 0.
  - `data0_o` = `data1_o` = 0.
  - `rvalid_o` = 0, `rdata_o` = 0.
  - `halted_o`, `cmd_busy_o`, `resumeack_o`, `cmderr_o` all 0.
- Reset mid-command or mid-resume aborts unconditionally to RUNNING. No response is issued for a request granted in the reset cycle.
- Back-to-back requests are allowed, one response per cycle.

## Test plan
- Reset, then a read of 0x400 -> `rvalid_o` one cycle after grant, `rdata_o` = 0. All status outputs 0.
- Write 0x100 -> `halted_o` = 1 next cycle. Then `cmd_go_i` -> FLAGS reads 0x1 and `cmd_busy_o` = 1. Write 0x104 -> FLAGS reads 0. Write 0x100 -> `cmd_busy_o` = 0.
- Halted, `dbg_we_i` idx1 = 0xDEADBEEF -> a read of 0x380 returns 0xDEADBEEF_00000000. Hart write 0x380 with `be_i` = 0x0F and data 0x12345678 -> `data0_o` = 0x12345678 and data1 is unchanged.
- During CMD, write 0x10C -> `cmderr_o` = 1, `cmd_busy_o` = 0, state HALTED. `cmderr_clr_i` -> `cmderr_o` = 0.
- Halted, `cmd_resume_i` -> FLAGS reads 0x2. Write 0x108 -> `resumeack_o` one-cycle pulse, then `halted_o` = 0. `cmd_go_i` while RUNNING -> ignored.
- Assert `rst_ni` low during CMD -> all outputs 0 asynchronously. After release, a read of 0x380 returns 0.

Source files
------------

// File: rtl/cva6_dm_mailbox.sv
// Debug-region responder for the CVA6 debug ROM handshake: decodes hart accesses,
// tracks run/halt/command/resume state and holds the two 32-bit data registers.
module cva6_dm_mailbox #(
   parameter int unsigned          AddrWidth = 64,
   parameter logic [AddrWidth-1:0] BaseAddr  = {AddrWidth{1'b0}}
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic                 we_i,
   input  logic [7:0]           be_i,
   input  logic [63:0]          wdata_i,
   output logic                 rvalid_o,
   output logic [63:0]          rdata_o,
   input  logic                 cmd_go_i,
   input  logic                 cmd_resume_i,
   input  logic                 cmderr_clr_i,
   input  logic                 dbg_we_i,
   input  logic                 dbg_idx_i,
   input  logic [31:0]          dbg_wdata_i,
   output logic [31:0]          data0_o,
   output logic [31:0]          data1_o,
   output logic                 halted_o,
   output logic                 cmd_busy_o,
   output logic                 resumeack_o,
   output logic                 cmderr_o
);

   localparam logic [1:0] ST_RUNNING  = 2'd0;
   localparam logic [1:0] ST_HALTED   = 2'd1;
   localparam logic [1:0] ST_CMD      = 2'd2;
   localparam logic [1:0] ST_RESUMING = 2'd3;

   localparam logic [AddrWidth-1:0] HaltedAddr    = BaseAddr + AddrWidth'(12'h100);
   localparam logic [AddrWidth-1:0] GoingAddr     = BaseAddr + AddrWidth'(12'h104);
   localparam logic [AddrWidth-1:0] ResumingAddr  = BaseAddr + AddrWidth'(12'h108);
   localparam logic [AddrWidth-1:0] ExceptionAddr = BaseAddr + AddrWidth'(12'h10C);
   localparam logic [AddrWidth-1:0] DataAddr      = BaseAddr + AddrWidth'(12'h380);
   localparam logic [AddrWidth-1:0] FlagsAddr     = BaseAddr + AddrWidth'(12'h400);
   localparam logic [AddrWidth-1:0] WordMask      = ~AddrWidth'(2'b11);
   localparam logic [AddrWidth-1:0] DwordMask     = ~AddrWidth'(3'b111);

   logic [1:0]  r_state;
   logic        r_go;
   logic        r_resume;
   logic        r_busy;
   logic        r_halted;
   logic        r_resumeack;
   logic        r_cmderr;
   logic [63:0] r_data;
   logic        r_rvalid;
   logic [63:0] r_rdata;

   logic        w_hit_halted;
   logic        w_hit_going;
   logic        w_hit_resuming;
   logic        w_hit_exception;
   logic        w_hit_data;
   logic        w_hit_flags;
   logic        w_wr;
   logic        w_wr_halted;
   logic        w_wr_going;
   logic        w_wr_resuming;
   logic        w_wr_exception;
   logic        w_wr_data;
   logic        w_dbg_wr;
   logic [1:0]  w_state_nxt;
   logic        w_go_nxt;
   logic        w_resume_nxt;
   logic        w_busy_nxt;
   logic        w_ack_nxt;
   logic        w_cmderr_set;
   logic        w_cmderr_nxt;
   logic [63:0] w_data_nxt;
   logic [63:0] w_rdata;

   // Masked compares keep every address bit referenced while ignoring the sub-word bits.
   assign w_hit_halted    = ((addr_i ^ HaltedAddr)    & WordMask)  == {AddrWidth{1'b0}};
   assign w_hit_going     = ((addr_i ^ GoingAddr)     & WordMask)  == {AddrWidth{1'b0}};
   assign w_hit_resuming  = ((addr_i ^ ResumingAddr)  & WordMask)  == {AddrWidth{1'b0}};
   assign w_hit_exception = ((addr_i ^ ExceptionAddr) & WordMask)  == {AddrWidth{1'b0}};
   assign w_hit_data      = ((addr_i ^ DataAddr)      & DwordMask) == {AddrWidth{1'b0}};
   assign w_hit_flags     = ((addr_i ^ FlagsAddr)     & DwordMask) == {AddrWidth{1'b0}};

   assign w_wr           = req_i & we_i & (|be_i);
   assign w_wr_halted    = w_wr & w_hit_halted;
   assign w_wr_going     = w_wr & w_hit_going;
   assign w_wr_resuming  = w_wr & w_hit_resuming;
   assign w_wr_exception = w_wr & w_hit_exception;
   assign w_wr_data      = w_wr & w_hit_data;
   assign w_dbg_wr       = dbg_we_i & ~r_busy;

   // Handshake state machine and go/resume/busy flag updates.
   always_comb begin
      w_state_nxt  = r_state;
      w_go_nxt     = r_go;
      w_resume_nxt = r_resume;
      w_busy_nxt   = r_busy;
      w_ack_nxt    = 1'b0;
      w_cmderr_set = 1'b0;
      case (r_state)
         ST_RUNNING: begin
            if (w_wr_halted) begin
               w_state_nxt = ST_HALTED;
            end else begin
               w_state_nxt = ST_RUNNING;
            end
         end
         ST_HALTED: begin
            if (cmd_go_i && !r_busy) begin
               w_go_nxt    = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_CMD;
            end else if (cmd_resume_i && !r_busy) begin
               w_resume_nxt = 1'b1;
               w_state_nxt  = ST_RESUMING;
            end else begin
               w_state_nxt = ST_HALTED;
            end
         end
         ST_CMD: begin
            if (w_wr_exception) begin
               w_cmderr_set = 1'b1;
               w_busy_nxt   = 1'b0;
               w_go_nxt     = 1'b0;
               w_state_nxt  = ST_HALTED;
            end else if (w_wr_halted) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_HALTED;
            end else if (w_wr_going) begin
               w_go_nxt = 1'b0;
            end else begin
               w_state_nxt = ST_CMD;
            end
         end
         ST_RESUMING: begin
            if (w_wr_resuming) begin
               w_resume_nxt = 1'b0;
               w_ack_nxt    = 1'b1;
               w_state_nxt  = ST_RUNNING;
            end else if (w_wr_halted) begin
               w_state_nxt = ST_HALTED;
            end else begin
               w_state_nxt = ST_RESUMING;
            end
         end
         default: begin
            w_state_nxt  = ST_RUNNING;
            w_go_nxt     = 1'b0;
            w_resume_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
         end
      endcase
   end

   // Sticky command error: a set in the same cycle as a clear takes precedence.
   always_comb begin
      if (w_cmderr_set) begin
         w_cmderr_nxt = 1'b1;
      end else if (cmderr_clr_i) begin
         w_cmderr_nxt = 1'b0;
      end else begin
         w_cmderr_nxt = r_cmderr;
      end
   end

   // Per-byte data merge: hart-enabled bytes first, then the debugger's selected word.
   always_comb begin
      w_data_nxt = r_data;
      for (int k = 0; k < 8; k++) begin
         if (w_wr_data && be_i[k]) begin
            w_data_nxt[8*k +: 8] = wdata_i[8*k +: 8];
         end else if (w_dbg_wr && ((k >= 4) == dbg_idx_i)) begin
            w_data_nxt[8*k +: 8] = dbg_wdata_i[8*(k%4) +: 8];
         end else begin
            w_data_nxt[8*k +: 8] = r_data[8*k +: 8];
         end
      end
   end

   // Read mux sampled in the grant cycle; write responses carry zero data.
   always_comb begin
      if (we_i) begin
         w_rdata = 64'd0;
      end else if (w_hit_data) begin
         w_rdata = r_data;
      end else if (w_hit_flags) begin
         w_rdata = {62'd0, r_resume, r_go};
      end else begin
         w_rdata = 64'd0;
      end
   end

   // State, flag, data and response registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_RUNNING;
         r_go        <= 1'b0;
         r_resume    <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_resumeack <= 1'b0;
         r_cmderr    <= 1'b0;
         r_data      <= 64'd0;
         r_rvalid    <= 1'b0;
         r_rdata     <= 64'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_go        <= w_go_nxt;
         r_resume    <= w_resume_nxt;
         r_busy      <= w_busy_nxt;
         r_halted    <= (w_state_nxt != ST_RUNNING);
         r_resumeack <= w_ack_nxt;
         r_cmderr    <= w_cmderr_nxt;
         r_data      <= w_data_nxt;
         r_rvalid    <= req_i;
         if (req_i) begin
            r_rdata <= w_rdata;
         end
      end
   end

   assign gnt_o       = req_i;
   assign rvalid_o    = r_rvalid;
   assign rdata_o     = r_rdata;
   assign data0_o     = r_data[31:0];
   assign data1_o     = r_data[63:32];
   assign halted_o    = r_halted;
   assign cmd_busy_o  = r_busy;
   assign resumeack_o = r_resumeack;
   assign cmderr_o    = r_cmderr;

endmodule

// File: tb/tb_cva6_dm_mailbox.sv
// Directed bench for cva6_dm_mailbox: response data checked through a scoreboard queue,
// status outputs checked with immediate assertions after each step.
module tb_cva6_dm_mailbox;

   typedef struct {
      bit          chk;
      logic [63:0] data;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        req;
   logic        gnt;
   logic [63:0] addr;
   logic        we;
   logic [7:0]  be;
   logic [63:0] wdata;
   logic        rvalid;
   logic [63:0] rdata;
   logic        cmd_go;
   logic        cmd_resume;
   logic        cmderr_clr;
   logic        dbg_we;
   logic        dbg_idx;
   logic [31:0] dbg_wdata;
   logic [31:0] data0;
   logic [31:0] data1;
   logic        halted;
   logic        busy;
   logic        resumeack;
   logic        cmderr;

   int    n_checks = 0;
   int    n_errors = 0;
   resp_t sb_q[$];

   always #5 clk = ~clk;

   cva6_dm_mailbox #(.AddrWidth(64), .BaseAddr(64'h0)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .req_i        (req),
      .gnt_o        (gnt),
      .addr_i       (addr),
      .we_i         (we),
      .be_i         (be),
      .wdata_i      (wdata),
      .rvalid_o     (rvalid),
      .rdata_o      (rdata),
      .cmd_go_i     (cmd_go),
      .cmd_resume_i (cmd_resume),
      .cmderr_clr_i (cmderr_clr),
      .dbg_we_i     (dbg_we),
      .dbg_idx_i    (dbg_idx),
      .dbg_wdata_i  (dbg_wdata),
      .data0_o      (data0),
      .data1_o      (data1),
      .halted_o     (halted),
      .cmd_busy_o   (busy),
      .resumeack_o  (resumeack),
      .cmderr_o     (cmderr)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag, input logic h, input logic b,
                               input logic ack, input logic err);
      check({tag, "_halted"},    64'(halted),    64'(h));
      check({tag, "_busy"},      64'(busy),      64'(b));
      check({tag, "_resumeack"}, 64'(resumeack), 64'(ack));
      check({tag, "_cmderr"},    64'(cmderr),    64'(err));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One granted request; the response is popped from the scoreboard one cycle later.
   task automatic issue(input string tag, input logic w, input logic [63:0] a,
                        input logic [7:0] b, input logic [63:0] wd, input logic [63:0] exp);
      resp_t r;
      req   = 1'b1;
      we    = w;
      addr  = a;
      be    = b;
      wdata = wd;
      #1;
      check({tag, "_gnt"}, 64'(gnt), 64'd1);
      r.chk  = !w;
      r.data = exp;
      sb_q.push_back(r);
      @(posedge clk);
      #1;
      req = 1'b0;
      we  = 1'b0;
      be  = 8'h00;
      check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
      if (rvalid && sb_q.size() > 0) begin
         r = sb_q.pop_front();
         if (r.chk) begin
            check({tag, "_rdata"}, rdata, r.data);
         end
      end
   endtask

   task automatic rd(input string tag, input logic [63:0] a, input logic [63:0] exp);
      issue(tag, 1'b0, a, 8'hFF, 64'd0, exp);
   endtask

   task automatic wr(input string tag, input logic [63:0] a, input logic [7:0] b,
                     input logic [63:0] wd);
      issue(tag, 1'b1, a, b, wd, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_ni = 1'b0; req = 1'b0; addr = 64'd0; we = 1'b0; be = 8'h00; wdata = 64'd0;
      cmd_go = 1'b0; cmd_resume = 1'b0; cmderr_clr = 1'b0;
      dbg_we = 1'b0; dbg_idx = 1'b0; dbg_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset_rvalid", 64'(rvalid), 64'd0);
      check("reset_rdata", rdata, 64'd0);
      check("reset_data", {data1, data0}, 64'd0);
      rst_ni = 1'b1;

      rd("flags_after_reset", 64'h400, 64'd0);
      check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      wr("wr_halted", 64'h100, 8'h0F, 64'd0);
      check_status("halted", 1'b1, 1'b0, 1'b0, 1'b0);
      cmd_go = 1'b1; step(); cmd_go = 1'b0;
      check_status("go", 1'b1, 1'b1, 1'b0, 1'b0);
      rd("flags_go", 64'h400, 64'h1);
      wr("wr_going", 64'h104, 8'hF0, 64'd0);
      rd("flags_going", 64'h400, 64'h0);
      check("busy_after_going", 64'(busy), 64'd1);
      wr("wr_halted_cmd", 64'h100, 8'h0F, 64'd0);
      check_status("cmd_done", 1'b1, 1'b0, 1'b0, 1'b0);

      dbg_we = 1'b1; dbg_idx = 1'b1; dbg_wdata = 32'hDEADBEEF; step(); dbg_we = 1'b0;
      check("dbg_data1", 64'(data1), 64'hDEADBEEF);
      rd("data_dbg", 64'h380, 64'hDEADBEEF_00000000);
      wr("hart_be0f", 64'h380, 8'h0F, 64'hAAAAAAAA_12345678);
      check("hart_data", {data1, data0}, 64'hDEADBEEF_12345678);

      dbg_we = 1'b1; dbg_idx = 1'b0; dbg_wdata = 32'h11223344;
      wr("merge_lo", 64'h380, 8'h03, 64'h00000000_0000CAFE);
      dbg_we = 1'b0;
      check("merge_lo_data0", 64'(data0), 64'h1122CAFE);
      dbg_we = 1'b1; dbg_idx = 1'b1; dbg_wdata = 32'h55667788;
      wr("merge_hi", 64'h384, 8'h30, 64'h00001234_00000000);
      dbg_we = 1'b0;
      check("merge_hi_data", {data1, data0}, 64'h55661234_1122CAFE);

      rd("b2b_data", 64'h380, 64'h55661234_1122CAFE);
      rd("b2b_data_hi", 64'h384, 64'h55661234_1122CAFE);
      rd("b2b_unmapped", 64'h200, 64'd0);
      wr("wr_unmapped", 64'h208, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
      wr("wr_flags", 64'h400, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
      rd("flags_ro", 64'h400, 64'd0);
      check("data_untouched", {data1, data0}, 64'h55661234_1122CAFE);

      cmd_go = 1'b1; step(); cmd_go = 1'b0;
      dbg_we = 1'b1; dbg_idx = 1'b0; dbg_wdata = 32'hFFFFFFFF; step(); dbg_we = 1'b0;
      check("dbg_while_busy", 64'(data0), 64'h1122CAFE);
      wr("wr_exception", 64'h10C, 8'hF0, 64'd0);
      check_status("exception", 1'b1, 1'b0, 1'b0, 1'b1);
      rd("flags_exception", 64'h400, 64'd0);
      cmderr_clr = 1'b1; step(); cmderr_clr = 1'b0;
      check("cmderr_clear", 64'(cmderr), 64'd0);

      cmd_go = 1'b1; step(); cmd_go = 1'b0;
      cmderr_clr = 1'b1;
      wr("exc_with_clr", 64'h10C, 8'hF0, 64'd0);
      cmderr_clr = 1'b0;
      check("set_beats_clr", 64'(cmderr), 64'd1);
      cmderr_clr = 1'b1; step(); cmderr_clr = 1'b0;
      check("cmderr_clear2", 64'(cmderr), 64'd0);

      cmd_go = 1'b1; cmd_resume = 1'b1; step(); cmd_go = 1'b0; cmd_resume = 1'b0;
      check("go_wins_busy", 64'(busy), 64'd1);
      rd("flags_go_wins", 64'h400, 64'h1);
      cmd_resume = 1'b1; step(); cmd_resume = 1'b0;
      rd("flags_resume_busy", 64'h400, 64'h1);
      wr("wr_going2", 64'h104, 8'hF0, 64'd0);
      wr("wr_halted2", 64'h100, 8'h0F, 64'd0);
      rd("flags_clean", 64'h400, 64'd0);

      cmd_resume = 1'b1; step(); cmd_resume = 1'b0;
      rd("flags_resume", 64'h400, 64'h2);
      check_status("resuming", 1'b1, 1'b0, 1'b0, 1'b0);
      wr("wr_resuming", 64'h108, 8'hFF, 64'd0);
      check_status("resumeack", 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      check("resumeack_pulse_end", 64'(resumeack), 64'd0);
      cmd_go = 1'b1; step(); cmd_go = 1'b0;
      check_status("go_running", 1'b0, 1'b0, 1'b0, 1'b0);
      rd("flags_running", 64'h400, 64'd0);

      wr("wr_halted3", 64'h100, 8'h01, 64'd0);
      cmd_go = 1'b1; step(); cmd_go = 1'b0;
      check("busy_before_reset", 64'(busy), 64'd1);
      rst_ni = 1'b0;
      req = 1'b1; we = 1'b0; addr = 64'h400; be = 8'hFF;
      #1;
      check_status("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check("async_reset_data", {data1, data0}, 64'd0);
      check("async_reset_rvalid", 64'(rvalid), 64'd0);
      step();
      check("no_resp_in_reset", 64'(rvalid), 64'd0);
      req = 1'b0;
      rst_ni = 1'b1;
      rd("data_after_reset", 64'h380, 64'd0);
      check_status("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
